// File: rtl/fpu_mult_pipe.sv
// fpu_mult_pipe: pre-normalisation floating-point multiplier datapath.
// Produces the XOR'd sign, the biased exponent sum and the full-width mantissa
// product, plus zero/inf/NaN classification, through a C_PIPE_STAGES deep
// pipeline that is stalled globally by a single advance enable.
// The whole result is computed combinationally ahead of the first register;
// the remaining stages only carry it forward.

module fpu_mult_pipe #(
    parameter int C_EXP          = 8,
    parameter int C_MANT         = 23,
    parameter int C_BIAS         = 127,
    parameter int C_EXP_PRENORM  = C_EXP + 2,
    parameter int C_MANT_PRENORM = 2 * (C_MANT + 1),
    parameter int C_PIPE_STAGES  = 2,   // legal range 1..4
    parameter int C_TAG_WIDTH    = 4
) (
    input  logic                             Clk_CI,
    input  logic                             Rst_RBI,
    input  logic                             Flush_SI,
    input  logic                             Valid_SI,
    output logic                             Ready_SO,
    input  logic                             Sign_a_DI,
    input  logic                             Sign_b_DI,
    input  logic [C_EXP-1:0]                 Exp_a_DI,
    input  logic [C_EXP-1:0]                 Exp_b_DI,
    input  logic [C_MANT:0]                  Mant_a_DI,
    input  logic [C_MANT:0]                  Mant_b_DI,
    input  logic [C_TAG_WIDTH-1:0]           Tag_DI,
    output logic                             Valid_SO,
    input  logic                             Ready_SI,
    output logic                             Sign_prenorm_DO,
    output logic signed [C_EXP_PRENORM-1:0]  Exp_prenorm_DO,
    output logic [C_MANT_PRENORM-1:0]        Mant_prenorm_DO,
    output logic                             Zero_SO,
    output logic                             Inf_SO,
    output logic                             NaN_SO,
    output logic [C_TAG_WIDTH-1:0]           Tag_DO
);

    localparam int LAST = C_PIPE_STAGES - 1;

    // One pipeline slot's payload; the valid bit lives in a separate vector.
    typedef struct packed {
        logic [C_TAG_WIDTH-1:0]    tag;
        logic                      sign;
        logic [C_EXP_PRENORM-1:0]  exp;
        logic [C_MANT_PRENORM-1:0] mant;
        logic                      zero;
        logic                      inf;
        logic                      nan;
    } stage_t;

    stage_t                   result;
    stage_t                   stage_d [C_PIPE_STAGES];
    stage_t                   stage_q [C_PIPE_STAGES];
    logic [C_PIPE_STAGES-1:0] valid_d;
    logic [C_PIPE_STAGES-1:0] valid_q;
    logic                     advance;

    logic exp_max_a, exp_max_b;
    logic frac_nz_a, frac_nz_b;
    logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    // Operand classification; denormals (exponent zero) count as zero.
    always_comb begin
        exp_max_a = &Exp_a_DI;
        exp_max_b = &Exp_b_DI;
        frac_nz_a = |Mant_a_DI[C_MANT-1:0];
        frac_nz_b = |Mant_b_DI[C_MANT-1:0];
        zero_a    = (Exp_a_DI == '0);
        zero_b    = (Exp_b_DI == '0);
        inf_a     = exp_max_a && !frac_nz_a;
        inf_b     = exp_max_b && !frac_nz_b;
        nan_a     = exp_max_a && frac_nz_a;
        nan_b     = exp_max_b && frac_nz_b;
    end

    // Arithmetic result and prioritised special flags for the incoming operands.
    always_comb begin
        result.tag  = Tag_DI;
        result.sign = Sign_a_DI ^ Sign_b_DI;
        // Zero-extended operands in the wider field keep a negative sum intact
        // as two's complement instead of wrapping inside C_EXP bits.
        result.exp  = C_EXP_PRENORM'(Exp_a_DI) + C_EXP_PRENORM'(Exp_b_DI)
                    - C_EXP_PRENORM'(C_BIAS);
        result.mant = C_MANT_PRENORM'(Mant_a_DI) * C_MANT_PRENORM'(Mant_b_DI);
        result.nan  = nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a);
        result.inf  = !result.nan && (inf_a || inf_b);
        result.zero = !result.nan && !result.inf && (zero_a || zero_b);
    end

    // Global stall: every stage moves together, and a flush blocks new input.
    always_comb begin
        Ready_SO = !Flush_SI && (Ready_SI || !valid_q[LAST]);
        advance  = Ready_SO;
    end

    // Next-state for valid bits and payload: shift on advance, clear valids on flush.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        valid_d = valid_q;
        stage_d = stage_q;
        if (Flush_SI) begin
            valid_d = '0;
        end else if (advance) begin
            valid_d[0] = Valid_SI;
            stage_d[0] = result;
            for (int i = 1; i < C_PIPE_STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Pipeline registers; reset discards any in-flight operation.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            valid_q <= '0;
            // NOTE: payload registers are reset as well, not only the valid
            // bits, so every output reads zero while and after reset.
            for (int i = 0; i < C_PIPE_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples the value
            // its predecessor held before this edge.
            valid_q <= valid_d;
            stage_q <= stage_d;
        end
    end

    // Outputs come straight from the last stage, so they hold while stalled.
    always_comb begin
        Valid_SO        = valid_q[LAST];
        Sign_prenorm_DO = stage_q[LAST].sign;
        Exp_prenorm_DO  = signed'(stage_q[LAST].exp);
        Mant_prenorm_DO = stage_q[LAST].mant;
        Zero_SO         = stage_q[LAST].zero;
        Inf_SO          = stage_q[LAST].inf;
        NaN_SO          = stage_q[LAST].nan;
        Tag_DO          = stage_q[LAST].tag;
    end

endmodule

// File: tb/tb_fpu_mult_pipe.sv
// tb_fpu_mult_pipe: table vectors and random traffic checked through a
// scoreboard queue, plus directed stall, flush, reset and latency sequences.

module tb_fpu_mult_pipe;

    typedef struct {
        logic        sa;
        logic        sb;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [23:0] ma;
        logic [23:0] mb;
        logic [3:0]  tag;
    } op_t;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic        zero;
        logic        inf;
        logic        nan;
        logic [3:0]  tag;
    } res_t;

    typedef struct {
        op_t  op;
        res_t res;
    } vec_t;

    logic               Clk_CI, Rst_RBI, Flush_SI, Valid_SI, Ready_SI;
    logic               Sign_a_DI, Sign_b_DI;
    logic [7:0]         Exp_a_DI, Exp_b_DI;
    logic [23:0]        Mant_a_DI, Mant_b_DI;
    logic [3:0]         Tag_DI;

    logic               Ready_SO, Valid_SO, Sign_prenorm_DO, Zero_SO, Inf_SO, NaN_SO;
    logic signed [9:0]  Exp_prenorm_DO;
    logic [47:0]        Mant_prenorm_DO;
    logic [3:0]         Tag_DO;
    logic [9:0]         exp_u;

    logic               rdy1, vld1, s1, z1, i1, n1;
    logic signed [9:0]  e1;
    logic [47:0]        m1;
    logic [3:0]         t1;
    logic               rdy4, vld4, s4, z4, i4, n4;
    logic signed [9:0]  e4;
    logic [47:0]        m4;
    logic [3:0]         t4;

    int   checks = 0;
    int   errors = 0;
    res_t cur_exp;
    res_t sb_q[$];
    logic [3:0] tag_log[$];
    vec_t vecs[11];

    assign exp_u = Exp_prenorm_DO;

    fpu_mult_pipe #(.C_PIPE_STAGES(2)) u_dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Flush_SI(Flush_SI),
        .Valid_SI(Valid_SI), .Ready_SO(Ready_SO),
        .Sign_a_DI(Sign_a_DI), .Sign_b_DI(Sign_b_DI),
        .Exp_a_DI(Exp_a_DI), .Exp_b_DI(Exp_b_DI),
        .Mant_a_DI(Mant_a_DI), .Mant_b_DI(Mant_b_DI), .Tag_DI(Tag_DI),
        .Valid_SO(Valid_SO), .Ready_SI(Ready_SI),
        .Sign_prenorm_DO(Sign_prenorm_DO), .Exp_prenorm_DO(Exp_prenorm_DO),
        .Mant_prenorm_DO(Mant_prenorm_DO), .Zero_SO(Zero_SO), .Inf_SO(Inf_SO),
        .NaN_SO(NaN_SO), .Tag_DO(Tag_DO)
    );

    fpu_mult_pipe #(.C_PIPE_STAGES(1)) u_dut1 (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Flush_SI(Flush_SI),
        .Valid_SI(Valid_SI), .Ready_SO(rdy1),
        .Sign_a_DI(Sign_a_DI), .Sign_b_DI(Sign_b_DI),
        .Exp_a_DI(Exp_a_DI), .Exp_b_DI(Exp_b_DI),
        .Mant_a_DI(Mant_a_DI), .Mant_b_DI(Mant_b_DI), .Tag_DI(Tag_DI),
        .Valid_SO(vld1), .Ready_SI(Ready_SI),
        .Sign_prenorm_DO(s1), .Exp_prenorm_DO(e1), .Mant_prenorm_DO(m1),
        .Zero_SO(z1), .Inf_SO(i1), .NaN_SO(n1), .Tag_DO(t1)
    );

    fpu_mult_pipe #(.C_PIPE_STAGES(4)) u_dut4 (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Flush_SI(Flush_SI),
        .Valid_SI(Valid_SI), .Ready_SO(rdy4),
        .Sign_a_DI(Sign_a_DI), .Sign_b_DI(Sign_b_DI),
        .Exp_a_DI(Exp_a_DI), .Exp_b_DI(Exp_b_DI),
        .Mant_a_DI(Mant_a_DI), .Mant_b_DI(Mant_b_DI), .Tag_DI(Tag_DI),
        .Valid_SO(vld4), .Ready_SI(Ready_SI),
        .Sign_prenorm_DO(s4), .Exp_prenorm_DO(e4), .Mant_prenorm_DO(m4),
        .Zero_SO(z4), .Inf_SO(i4), .NaN_SO(n4), .Tag_DO(t4)
    );

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the arithmetic and flag priority.
    function automatic res_t model(input op_t o);
        res_t r;
        int   e  = int'(o.ea) + int'(o.eb) - 127;
        logic az = (o.ea == 8'd0);
        logic bz = (o.eb == 8'd0);
        logic ai = (o.ea == 8'hFF) && (o.ma[22:0] == 23'd0);
        logic bi = (o.eb == 8'hFF) && (o.mb[22:0] == 23'd0);
        logic an = (o.ea == 8'hFF) && (o.ma[22:0] != 23'd0);
        logic bn = (o.eb == 8'hFF) && (o.mb[22:0] != 23'd0);
        r.sign = o.sa ^ o.sb;
        r.exp  = e[9:0];
        r.mant = 48'(o.ma) * 48'(o.mb);
        r.nan  = an | bn | (ai & bz) | (bi & az);
        r.inf  = !r.nan & (ai | bi);
        r.zero = !r.nan & !r.inf & (az | bz);
        r.tag  = o.tag;
        return r;
    endfunction

    function automatic logic [7:0] pick_exp();
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'hFF;
            2:       return 8'd1;
            3:       return 8'd254;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic op_t rand_op(input logic [3:0] tag);
        op_t o;
        o.sa  = 1'($urandom);
        o.sb  = 1'($urandom);
        o.ea  = pick_exp();
        o.eb  = pick_exp();
        o.ma  = {1'b1, 23'($urandom)};
        o.mb  = {1'b1, 23'($urandom)};
        if ($urandom_range(0, 3) == 0) o.ma[22:0] = 23'd0;
        if ($urandom_range(0, 3) == 0) o.mb[22:0] = 23'd0;
        o.tag = tag;
        return o;
    endfunction

    task automatic compare_out(input res_t r);
        check("sign", 64'(Sign_prenorm_DO), 64'(r.sign));
        check("exp",  64'(exp_u),           64'(r.exp));
        check("mant", 64'(Mant_prenorm_DO), 64'(r.mant));
        check("zero", 64'(Zero_SO),         64'(r.zero));
        check("inf",  64'(Inf_SO),          64'(r.inf));
        check("nan",  64'(NaN_SO),          64'(r.nan));
        check("tag",  64'(Tag_DO),          64'(r.tag));
    endtask

    // Scoreboard: compare the head while Valid_SO is up (also while stalled),
    // pop on output transfer, push on input transfer, drop everything on flush.
    always @(negedge Clk_CI) begin
        if (Rst_RBI) begin
            if (Valid_SO) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid got tag %0h expected no output at %0t", Tag_DO, $time);
                end else begin
                    compare_out(sb_q[0]);
                    if (Ready_SI) begin
                        tag_log.push_back(Tag_DO);
                        void'(sb_q.pop_front());
                    end
                end
            end
            if (Flush_SI) sb_q.delete();
            else if (Valid_SI && Ready_SO) sb_q.push_back(cur_exp);
        end
    end

    task automatic next_cycle();
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic send(input op_t o, input res_t r);
        int g = 0;
        Sign_a_DI = o.sa;
        Sign_b_DI = o.sb;
        Exp_a_DI  = o.ea;
        Exp_b_DI  = o.eb;
        Mant_a_DI = o.ma;
        Mant_b_DI = o.mb;
        Tag_DI    = o.tag;
        cur_exp   = r;
        Valid_SI  = 1'b1;
        @(negedge Clk_CI);
        while (!Ready_SO && g < 200) begin
            @(negedge Clk_CI);
            g++;
        end
        check("accept", 64'(Ready_SO), 64'(1));
        next_cycle();
        Valid_SI = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (sb_q.size() != 0 && g < 100) begin
            @(posedge Clk_CI);
            g++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'(0));
        next_cycle();
    endtask

    initial begin
        int   lat1, lat2, lat4;
        logic stop;
        op_t  o;

        vecs[0]  = '{'{1'b0, 1'b1, 8'd127, 8'd128, 24'hC00000, 24'h800000, 4'd0},
                     '{1'b1, 10'h080, 48'h600000000000, 1'b0, 1'b0, 1'b0, 4'd0}};
        vecs[1]  = '{'{1'b0, 1'b0, 8'd1,   8'd1,   24'h800000, 24'h800000, 4'd1},
                     '{1'b0, 10'h383, 48'h400000000000, 1'b0, 1'b0, 1'b0, 4'd1}};
        vecs[2]  = '{'{1'b0, 1'b0, 8'd255, 8'd0,   24'h800000, 24'h000000, 4'd2},
                     '{1'b0, 10'h080, 48'h000000000000, 1'b0, 1'b0, 1'b1, 4'd2}};
        vecs[3]  = '{'{1'b1, 1'b0, 8'd255, 8'd127, 24'h800001, 24'h800000, 4'd3},
                     '{1'b1, 10'h0FF, 48'h400000800000, 1'b0, 1'b0, 1'b1, 4'd3}};
        vecs[4]  = '{'{1'b1, 1'b0, 8'd255, 8'd127, 24'h800000, 24'h800000, 4'd4},
                     '{1'b1, 10'h0FF, 48'h400000000000, 1'b0, 1'b1, 1'b0, 4'd4}};
        vecs[5]  = '{'{1'b1, 1'b1, 8'd0,   8'd128, 24'h000000, 24'h800000, 4'd5},
                     '{1'b0, 10'h001, 48'h000000000000, 1'b1, 1'b0, 1'b0, 4'd5}};
        vecs[6]  = '{'{1'b0, 1'b1, 8'd254, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 4'd6},
                     '{1'b1, 10'h17D, 48'hFFFFFE000001, 1'b0, 1'b0, 1'b0, 4'd6}};
        vecs[7]  = '{'{1'b0, 1'b0, 8'd0,   8'd0,   24'h000000, 24'h000000, 4'd7},
                     '{1'b0, 10'h381, 48'h000000000000, 1'b1, 1'b0, 1'b0, 4'd7}};
        vecs[8]  = '{'{1'b0, 1'b0, 8'd0,   8'd127, 24'h400000, 24'h800000, 4'd8},
                     '{1'b0, 10'h000, 48'h200000000000, 1'b1, 1'b0, 1'b0, 4'd8}};
        vecs[9]  = '{'{1'b1, 1'b1, 8'd255, 8'd0,   24'hC00000, 24'h000000, 4'd9},
                     '{1'b0, 10'h080, 48'h000000000000, 1'b0, 1'b0, 1'b1, 4'd9}};
        vecs[10] = '{'{1'b0, 1'b0, 8'd255, 8'd255, 24'h800000, 24'h800000, 4'd10},
                     '{1'b0, 10'h17F, 48'h400000000000, 1'b0, 1'b1, 1'b0, 4'd10}};

        Rst_RBI   = 1'b0;
        Flush_SI  = 1'b0;
        Valid_SI  = 1'b0;
        Ready_SI  = 1'b1;
        Sign_a_DI = 1'b0;
        Sign_b_DI = 1'b0;
        Exp_a_DI  = '0;
        Exp_b_DI  = '0;
        Mant_a_DI = '0;
        Mant_b_DI = '0;
        Tag_DI    = '0;
        cur_exp   = vecs[0].res;

        // Reset state.
        #23;
        check("rst_valid", 64'(Valid_SO), 64'(0));
        check("rst_mant",  64'(Mant_prenorm_DO), 64'(0));
        check("rst_exp",   64'(exp_u), 64'(0));
        check("rst_flags", 64'({Zero_SO, Inf_SO, NaN_SO, Sign_prenorm_DO}), 64'(0));
        check("rst_tag",   64'(Tag_DO), 64'(0));
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        #1;
        check("rst_ready", 64'(Ready_SO), 64'(1));
        next_cycle();

        // Latency of the 1.5*2.0 case on 1-, 2- and 4-stage instances.
        send(vecs[0].op, vecs[0].res);
        lat1 = 0;
        lat2 = 0;
        lat4 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk_CI);
            if (vld1 && lat1 == 0) begin
                lat1 = k;
                check("p1_mant", 64'(m1), 64'(48'h600000000000));
                check("p1_exp",  64'(10'(e1)), 64'(10'h080));
            end
            if (Valid_SO && lat2 == 0) lat2 = k;
            if (vld4 && lat4 == 0) begin
                lat4 = k;
                check("p4_mant", 64'(m4), 64'(48'h600000000000));
                check("p4_sign", 64'(s4), 64'(1));
            end
        end
        check("latency_p1", 64'(lat1), 64'(1));
        check("latency_p2", 64'(lat2), 64'(2));
        check("latency_p4", 64'(lat4), 64'(4));
        drain();

        // Table vectors, back to back.
        foreach (vecs[i]) send(vecs[i].op, vecs[i].res);
        drain();

        // Four-op stream with the consumer stalled for three cycles.
        tag_log.delete();
        fork
            begin
                for (int t = 0; t < 4; t++) begin
                    o = rand_op(4'(t));
                    send(o, model(o));
                end
            end
            begin
                repeat (3) @(posedge Clk_CI);
                #1 Ready_SI = 1'b0;
                repeat (3) @(posedge Clk_CI);
                #1 Ready_SI = 1'b1;
            end
        join
        drain();
        check("stream_count", 64'(tag_log.size()), 64'(4));
        for (int t = 0; t < 4; t++) begin
            if (t < tag_log.size()) check("stream_order", 64'(tag_log[t]), 64'(t));
        end

        // Flush with a full pipe while the head transfers out the same cycle.
        Ready_SI = 1'b0;
        send(vecs[1].op, vecs[1].res);
        send(vecs[6].op, vecs[6].res);
        check("full_valid", 64'(Valid_SO), 64'(1));
        tag_log.delete();
        Flush_SI  = 1'b1;
        Ready_SI  = 1'b1;
        Valid_SI  = 1'b1;
        Tag_DI    = 4'd12;
        #1;
        check("flush_ready", 64'(Ready_SO), 64'(0));
        next_cycle();
        Flush_SI = 1'b0;
        Valid_SI = 1'b0;
        check("flush_valid", 64'(Valid_SO), 64'(0));
        check("flush_head_out", 64'(tag_log.size()), 64'(1));
        send(vecs[4].op, vecs[4].res);
        lat2 = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk_CI);
            if (Valid_SO && lat2 == 0) lat2 = k;
        end
        check("flush_latency", 64'(lat2), 64'(2));
        drain();

        // Random traffic with random consumer back-pressure and gaps.
        stop = 1'b0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    o = rand_op(4'($urandom));
                    send(o, model(o));
                    repeat ($urandom_range(0, 2)) next_cycle();
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    next_cycle();
                    Ready_SI = ($urandom_range(0, 2) != 0);
                end
                Ready_SI = 1'b1;
            end
        join
        drain();

        // Asynchronous reset in the middle of a stalled stream.
        Ready_SI = 1'b0;
        send(vecs[6].op, vecs[6].res);
        send(vecs[3].op, vecs[3].res);
        #3;
        Rst_RBI = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_valid", 64'(Valid_SO), 64'(0));
        check("mid_rst_mant",  64'(Mant_prenorm_DO), 64'(0));
        check("mid_rst_exp",   64'(exp_u), 64'(0));
        check("mid_rst_flags", 64'({Zero_SO, Inf_SO, NaN_SO, Sign_prenorm_DO}), 64'(0));
        check("mid_rst_tag",   64'(Tag_DO), 64'(0));
        @(negedge Clk_CI);
        #2;
        Rst_RBI  = 1'b1;
        Ready_SI = 1'b1;
        #1;
        check("post_rst_ready", 64'(Ready_SO), 64'(1));
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk_CI);
            check("post_rst_idle", 64'(Valid_SO), 64'(0));
        end
        next_cycle();
        send(vecs[0].op, vecs[0].res);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
